pe_seq_ctrl: RTL and testbench
==============================

Name: pe_seq_ctrl

Overview:
- Per-lane command sequencer that drives the four 64-bit input lanes (D/D_VALID/D_BP) of the pe_add1 processing element.
- Software or a testbench loads DEST/LEN and pulses GO; the block emits one header word (DEST) followed by LEN payload words, honouring backpressure.
- It pulses DONE when the last word has been accepted.
- Sits between the host command registers and the PE input ports; lanes run fully independently.

Parameters:
- NLANE, 4, number of independent lanes.
- W, 64, data word width.
- LENW, 32, width of the LEN field and payload counter.

Ports:
- CLK  in  1  single clock, all logic rising-edge.
- RST  in  1  asynchronous, active-low reset.
- GO  in  [NLANE-1:0]  start request per lane; sampled only in IDLE.
- DEST  in  [NLANE-1:0][W-1:0]  header word; captured on accepted GO.
- LEN  in  [NLANE-1:0][LENW-1:0]  payload word count; captured on accepted GO.
- BUSY  out  [NLANE-1:0]  lane not IDLE.
- DONE  out  [NLANE-1:0]  one-cycle pulse after the last word is transferred.
- D  out  [NLANE-1:0][W-1:0]  data to PE.
- D_VALID  out  [NLANE-1:0]  D holds a valid word.
- D_BP  in  [NLANE-1:0]  backpressure from PE; high = not accepted this cycle.

Behaviour:
- Reset (RST low, asynchronous): all lanes go to IDLE; BUSY=0, DONE=0, D_VALID=0, D=0; captured DEST/LEN and counters cleared. Takes effect immediately, including mid-packet; no partial-packet resumption after release.
- Transfer rule: a word moves on a rising edge where D_VALID=1 and D_BP=0. BP is zero-latency.
- While D_BP=1, D and D_VALID stay stable; the word may not change or drop.
- Per-lane FSM, states IDLE, HDR, PAY, FIN:
  - IDLE: D_VALID=0. GO=1 captures DEST/LEN, clears payload counter CNT, and moves to HDR on the next edge, so the first D_VALID appears 1 cycle after GO.
  - HDR: D=captured DEST, D_VALID=1. On transfer, go to PAY if LEN!=0, otherwise to FIN.
  - PAY: D = CNT zero-extended to W (0,1,2,...), D_VALID=1. On transfer, CNT increments. When the transfer has CNT==LEN-1, go to FIN.
  - FIN: D_VALID=0, DONE=1 for exactly one cycle, then IDLE. BUSY=1 in HDR/PAY/FIN.
- GO while BUSY is ignored and not queued. A GO held high continuously restarts on the first IDLE cycle (the cycle after FIN).
- Minimum packet (LEN=0) spans 3 cycles GO→DONE with no BP. A LEN=N packet takes N+1 transfers with no bubbles between words.
- CNT is LENW bits. LEN=2^LENW-1 is legal; CNT never wraps, since the terminal compare precedes increment overflow.
- DEST/LEN changing after GO has no effect on the packet in flight.
- Lanes share no state; simultaneous GO on all lanes starts all lanes in the same cycle.

Optional Feature:
- Macro PE_SEQ_STALL_CNT_EN.
- Defined: adds output STALL_CNT [NLANE-1:0][31:0], counting per lane the cycles with D_VALID=1 and D_BP=1 during the current/last packet.
  - Cleared on accepted GO, held after FIN, saturating at 32'hFFFF_FFFF, reset to 0.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared package pe_pkg:
  - constants NLANE, W, LENW;
  - typedef seq_state_t enum {IDLE, HDR, PAY, FIN};
  - typedefs word_t (logic [W-1:0]) and len_t (logic [LENW-1:0]).
- Sub-module pe_seq_lane: one lane's FSM, capture registers, CNT and optional stall counter.
- pe_seq_ctrl instantiates NLANE copies in a generate loop with no glue logic.

Test Plan:
- Lane 0, GO with DEST={8'h01,56'h4}, LEN=3, D_BP=0:
  - D_VALID high for 4 consecutive cycles starting 1 cycle after GO;
  - D = 0x0100000000000004, 0, 1, 2;
  - DONE pulses the following cycle.
- All four lanes GO in the same cycle, LEN=500, D_BP=0 → 501 transfers each; DONE on all lanes in the same cycle, 502 cycles after GO.
- LEN=0 on lane 2 → single header transfer, DONE 2 cycles after GO, no payload.
- Lane 1, LEN=5, D_BP pulsed high for 3 cycles on payload word 2 → D held at 2 throughout; sequence still 0..4 with no duplicates or skips.
  - With PE_SEQ_STALL_CNT_EN: STALL_CNT[1]=3.
- GO reasserted on lane 3 while BUSY → ignored; the packet completes unchanged.
  - GO held high → the next packet starts the cycle after DONE.
- RST driven low mid-PAY on lane 0 (LEN=100, CNT=40):
  - D_VALID and BUSY drop immediately (asynchronously);
  - after release, the lane stays IDLE until a new GO;
  - the new GO with LEN=2 yields header, 0, 1.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and types for the pe_add1 input-lane sequencer.
package pe_pkg;
    localparam int NLANE = 4;
    localparam int W     = 64;
    localparam int LENW  = 32;
    typedef enum logic [1:0] {IDLE, HDR, PAY, FIN} seq_state_t;
    typedef logic [W-1:0]    word_t;
    typedef logic [LENW-1:0] len_t;
endpackage

// File: rtl/pe_seq_lane.sv
// pe_seq_lane: one lane's header+payload sequencer with backpressure.
// Optional stall counter enabled by PE_SEQ_STALL_CNT_EN.
module pe_seq_lane
    import pe_pkg::*;
(
`ifdef PE_SEQ_STALL_CNT_EN
    output logic [31:0]     stall_cnt,
`endif
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [W-1:0]    dest,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    d,
    output logic            d_valid,
    input  logic            d_bp
);
    seq_state_t state_q, state_d;
    word_t      dest_q, dest_d;
    len_t       len_q, len_d, cnt_q, cnt_d;
    logic       xfer;

    assign busy    = state_q != IDLE;
    assign done    = state_q == FIN;
    assign d_valid = state_q == HDR || state_q == PAY;
    assign d       = state_q == HDR ? dest_q : state_q == PAY ? word_t'(cnt_q) : '0;
    assign xfer    = d_valid && !d_bp;

    // Terminal compare on cnt_q == len_q-1 happens before the increment, so CNT never wraps.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (go) begin
                state_d = HDR;
                dest_d  = dest;
                len_d   = len;
                cnt_d   = '0;
            end
            HDR: if (xfer) state_d = (len_q != '0) ? PAY : FIN;
            PAY: if (xfer) begin
                cnt_d   = cnt_q + len_t'(1);
                state_d = (cnt_q == len_q - len_t'(1)) ? FIN : PAY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PE_SEQ_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    always_comb
        stall_d = (state_q == IDLE && go) ? '0 :
                  (d_valid && d_bp && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
    assign stall_cnt = stall_q;
`endif
endmodule

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: NLANE independent command sequencers feeding the pe_add1 input lanes.
// Define PE_SEQ_STALL_CNT_EN to add the per-lane STALL_CNT output.
module pe_seq_ctrl
    import pe_pkg::*;
(
`ifdef PE_SEQ_STALL_CNT_EN
    output logic [NLANE-1:0][31:0]     STALL_CNT,
`endif
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NLANE-1:0]           GO,
    input  logic [NLANE-1:0][W-1:0]    DEST,
    input  logic [NLANE-1:0][LENW-1:0] LEN,
    output logic [NLANE-1:0]           BUSY,
    output logic [NLANE-1:0]           DONE,
    output logic [NLANE-1:0][W-1:0]    D,
    output logic [NLANE-1:0]           D_VALID,
    input  logic [NLANE-1:0]           D_BP
);
    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        pe_seq_lane u_lane (
`ifdef PE_SEQ_STALL_CNT_EN
            .stall_cnt (STALL_CNT[i]),
`endif
            .clk       (CLK),
            .rst_n     (RST),
            .go        (GO[i]),
            .dest      (DEST[i]),
            .len       (LEN[i]),
            .busy      (BUSY[i]),
            .done      (DONE[i]),
            .d         (D[i]),
            .d_valid   (D_VALID[i]),
            .d_bp      (D_BP[i])
        );
    end
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed, table-driven self-checking bench for pe_seq_ctrl.
module tb_pe_seq_ctrl;
    import pe_pkg::*;

    logic                       CLK = 1'b0;
    logic                       RST;
    logic [NLANE-1:0]           GO, BUSY, DONE, D_VALID, D_BP;
    logic [NLANE-1:0][W-1:0]    DEST, D;
    logic [NLANE-1:0][LENW-1:0] LEN;
`ifdef PE_SEQ_STALL_CNT_EN
    logic [NLANE-1:0][31:0]     STALL_CNT;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int xf[NLANE], dcyc[NLANE], bad[NLANE];
    int held_bad, done_c;
    logic [63:0] got[$];
    logic [63:0] exp_seq[6];

    typedef struct {
        int              lane;
        logic            go;
        logic [W-1:0]    dest;
        logic [LENW-1:0] len;
        logic            bp;
        logic            e_valid;
        logic [W-1:0]    e_d;
        logic            e_busy;
        logic            e_done;
    } vec_t;
    vec_t vt[9];

    always #5 CLK = ~CLK;

    pe_seq_ctrl dut (
`ifdef PE_SEQ_STALL_CNT_EN
        .STALL_CNT (STALL_CNT),
`endif
        .CLK       (CLK),
        .RST       (RST),
        .GO        (GO),
        .DEST      (DEST),
        .LEN       (LEN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .D         (D),
        .D_VALID   (D_VALID),
        .D_BP      (D_BP)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        GO   = '0;
        D_BP = '0;
        GO[v.lane]   = v.go;
        DEST[v.lane] = v.dest;
        LEN[v.lane]  = v.len;
        D_BP[v.lane] = v.bp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 1'b1, 64'h0100_0000_0000_0004, 32'd3, 1'b0, 1'b1, 64'h0100_0000_0000_0004, 1'b1, 1'b0};
        vt[1] = '{0, 1'b0, 64'hFFFF_0000_0000_FFFF, 32'd9, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
        vt[2] = '{0, 1'b0, 64'hFFFF_0000_0000_FFFF, 32'd9, 1'b0, 1'b1, 64'd1, 1'b1, 1'b0};
        vt[3] = '{0, 1'b0, 64'hFFFF_0000_0000_FFFF, 32'd9, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
        vt[4] = '{0, 1'b0, 64'hFFFF_0000_0000_FFFF, 32'd9, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
        vt[5] = '{0, 1'b0, 64'hFFFF_0000_0000_FFFF, 32'd9, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0};
        vt[6] = '{2, 1'b1, 64'h22,                  32'd0, 1'b0, 1'b1, 64'h22, 1'b1, 1'b0};
        vt[7] = '{2, 1'b0, 64'h99,                  32'd5, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
        vt[8] = '{2, 1'b0, 64'h99,                  32'd5, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0};

        RST = 1'b0; GO = '0; DEST = '0; LEN = '0; D_BP = '0;
        repeat (2) @(negedge CLK);
        chk("reset busy", 64'(BUSY), 64'd0);
        chk("reset done", 64'(DONE), 64'd0);
        chk("reset valid", 64'(D_VALID), 64'd0);
        chk("reset d_or", 64'(D[0] | D[1] | D[2] | D[3]), 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        // basic packets: lane 0 LEN=3, lane 2 LEN=0
        for (int k = 0; k < 9; k++) begin
            apply(vt[k]);
            @(negedge CLK);
            chk($sformatf("v%0d valid", k), 64'(D_VALID[vt[k].lane]), 64'(vt[k].e_valid));
            chk($sformatf("v%0d d", k), D[vt[k].lane], vt[k].e_d);
            chk($sformatf("v%0d busy", k), 64'(BUSY[vt[k].lane]), 64'(vt[k].e_busy));
            chk($sformatf("v%0d done", k), 64'(DONE[vt[k].lane]), 64'(vt[k].e_done));
        end
        GO = '0;
        @(negedge CLK);

        // all lanes, LEN=500, simultaneous start
        for (int l = 0; l < NLANE; l++) begin
            DEST[l] = 64'hA0 + 64'(l);
            LEN[l]  = 32'd500;
            xf[l] = 0; dcyc[l] = 0; bad[l] = 0;
        end
        GO = '1;
        @(negedge CLK);
        GO = '0;
        for (int c = 1; c <= 600; c++) begin
            for (int l = 0; l < NLANE; l++) begin
                if (D_VALID[l]) begin
                    if (D[l] !== ((xf[l] == 0) ? DEST[l] : 64'(xf[l] - 1))) bad[l]++;
                    xf[l]++;
                end
                if (DONE[l] && dcyc[l] == 0) dcyc[l] = c;
            end
            if (dcyc[0] != 0 && dcyc[1] != 0 && dcyc[2] != 0 && dcyc[3] != 0) break;
            @(negedge CLK);
        end
        for (int l = 0; l < NLANE; l++) begin
            chk($sformatf("l500 lane%0d xfers", l), 64'(xf[l]), 64'd501);
            chk($sformatf("l500 lane%0d done_cycle", l), 64'(dcyc[l]), 64'd502);
            chk($sformatf("l500 lane%0d data_errs", l), 64'(bad[l]), 64'd0);
        end
        @(negedge CLK);

        // lane 1 LEN=5 with 3-cycle backpressure on payload word 2
        GO[1] = 1'b1; DEST[1] = 64'hB1; LEN[1] = 32'd5;
        @(negedge CLK);
        GO = '0;
        held_bad = 0; done_c = 0;
        got.delete();
        for (int c = 1; c <= 40; c++) begin
            D_BP[1] = (c >= 4 && c <= 6);
            if (D_BP[1] && (D_VALID[1] !== 1'b1 || D[1] !== 64'd2)) held_bad++;
            if (D_VALID[1] && !D_BP[1]) got.push_back(D[1]);
            if (DONE[1]) begin
                done_c = c;
                break;
            end
            @(negedge CLK);
        end
        D_BP = '0;
        exp_seq = '{64'hB1, 64'd0, 64'd1, 64'd2, 64'd3, 64'd4};
        chk("bp held word", 64'(held_bad), 64'd0);
        chk("bp xfer count", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("bp word%0d", i), (i < got.size()) ? got[i] : 64'hX, exp_seq[i]);
        chk("bp done cycle", 64'(done_c), 64'd10);
`ifdef PE_SEQ_STALL_CNT_EN
        chk("bp stall_cnt", 64'(STALL_CNT[1]), 64'd3);
`endif
        @(negedge CLK);

        // lane 3: GO held through a packet is ignored, then restarts after DONE
        GO[3] = 1'b1; DEST[3] = 64'hC0; LEN[3] = 32'd2;
        @(negedge CLK);
        DEST[3] = 64'hC1; LEN[3] = 32'd7;
        chk("hold c1 d", D[3], 64'hC0);
        @(negedge CLK);
        chk("hold c2 d", D[3], 64'd0);
        @(negedge CLK);
        chk("hold c3 d", D[3], 64'd1);
        @(negedge CLK);
        chk("hold c4 done", 64'(DONE[3]), 64'd1);
        chk("hold c4 valid", 64'(D_VALID[3]), 64'd0);
        @(negedge CLK);
        chk("hold c5 busy", 64'(BUSY[3]), 64'd0);
        @(negedge CLK);
        GO = '0;
        chk("hold c6 d", D[3], 64'hC1);
        chk("hold c6 valid", 64'(D_VALID[3]), 64'd1);
        done_c = 0;
        for (int c = 6; c <= 40; c++) begin
            if (DONE[3]) begin
                done_c = c;
                break;
            end
            @(negedge CLK);
        end
        chk("hold pkt2 done cycle", 64'(done_c), 64'd14);
        @(negedge CLK);

        // asynchronous reset in the middle of a long payload on lane 0
        GO[0] = 1'b1; DEST[0] = 64'hD0; LEN[0] = 32'd100;
        @(negedge CLK);
        GO = '0;
        repeat (41) @(negedge CLK);
        chk("rst pre cnt", D[0], 64'd40);
        #2 RST = 1'b0;
        #1;
        chk("rst async valid", 64'(D_VALID[0]), 64'd0);
        chk("rst async busy", 64'(BUSY[0]), 64'd0);
        chk("rst async d", D[0], 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("rst idle%0d busy", i), 64'(BUSY[0]), 64'd0);
        end
        GO[0] = 1'b1; DEST[0] = 64'hE0; LEN[0] = 32'd2;
        @(negedge CLK);
        GO = '0;
        chk("rst new hdr", D[0], 64'hE0);
        @(negedge CLK);
        chk("rst new p0", D[0], 64'd0);
        @(negedge CLK);
        chk("rst new p1", D[0], 64'd1);
        @(negedge CLK);
        chk("rst new done", 64'(DONE[0]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
